// File: rtl/matrix_scan_ctrl.sv
// Scans a rectangular matrix region row-major and reports sum/max/count/err; result at T+N+LATENCY+1.
// Commands are taken only in IDLE; the result is held in DONE until res_ready_i, so the consumer stalls the controller.
module matrix_scan_ctrl #(
    parameter int MAX_VALUE = 255,
    parameter int NUM_X     = 4,
    parameter int NUM_Y     = 4,
    parameter int LATENCY   = 1,
    localparam int NUM_WIDTH = $clog2(MAX_VALUE + 1),
    localparam int X_IDX     = $clog2(NUM_X),
    localparam int Y_IDX     = $clog2(NUM_Y),
    localparam int CNT_W     = $clog2(NUM_X * NUM_Y + 1),
    localparam int SUM_W     = NUM_WIDTH + CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [X_IDX-1:0]     cmd_x0_i,
    input  logic [X_IDX-1:0]     cmd_x1_i,
    input  logic [Y_IDX-1:0]     cmd_y0_i,
    input  logic [Y_IDX-1:0]     cmd_y1_i,
    output logic [X_IDX-1:0]     mtx_x_idx_o,
    output logic [Y_IDX-1:0]     mtx_y_idx_o,
    input  logic [NUM_WIDTH-1:0] mtx_value_i,
    input  logic                 mtx_valid_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [SUM_W-1:0]     res_sum_o,
    output logic [NUM_WIDTH-1:0] res_max_o,
    output logic [CNT_W-1:0]     res_count_o,
    output logic                 res_err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [X_IDX:0] X_LIM = (X_IDX + 1)'(NUM_X);
    localparam logic [Y_IDX:0] Y_LIM = (Y_IDX + 1)'(NUM_Y);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [X_IDX-1:0]       r_x0;
    logic [X_IDX-1:0]       r_x1;
    logic [Y_IDX-1:0]       r_y1;
    logic [X_IDX-1:0]       r_x;
    logic [Y_IDX-1:0]       r_y;
    logic [LATENCY-1:0]     r_tag;
    logic [LATENCY-1:0]     w_tag_next;
    logic [SUM_W-1:0]       r_sum;
    logic [NUM_WIDTH-1:0]   r_max;
    logic [CNT_W-1:0]       r_count;
    logic                   r_err;
    logic                   w_accept;
    logic                   w_bad_region;
    logic                   w_issue;
    logic                   w_last_pair;
    logic                   w_tag_out;

    assign w_accept     = cmd_valid_i && (r_state == IDLE);
    assign w_bad_region = (cmd_x0_i > cmd_x1_i) || (cmd_y0_i > cmd_y1_i) ||
                          ({1'b0, cmd_x1_i} >= X_LIM) || ({1'b0, cmd_y1_i} >= Y_LIM);
    assign w_issue      = (r_state == ISSUE);
    assign w_last_pair  = (r_x == r_x1) && (r_y == r_y1);
    // Each issued pair pushes a tag; it pops out exactly LATENCY cycles later with its return.
    assign w_tag_next   = LATENCY'({r_tag, w_issue});
    assign w_tag_out    = r_tag[LATENCY-1];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid_i) w_state_next = w_bad_region ? DONE : ISSUE;
            ISSUE:   if (w_last_pair) w_state_next = DRAIN;
            DRAIN:   if (w_tag_next == '0) w_state_next = DONE;
            DONE:    if (res_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (r_state == IDLE);
        res_valid_o = (r_state == DONE);
        mtx_x_idx_o = w_issue ? r_x : '0;
        mtx_y_idx_o = w_issue ? r_y : '0;
        res_sum_o   = r_sum;
        res_max_o   = r_max;
        res_count_o = r_count;
        res_err_o   = r_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_tag   <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_sum   <= '0;
            r_max   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tag   <= w_tag_next;
            if (w_accept) begin
                r_x0    <= cmd_x0_i;
                r_x1    <= cmd_x1_i;
                r_y1    <= cmd_y1_i;
                r_x     <= cmd_x0_i;
                r_y     <= cmd_y0_i;
                r_sum   <= '0;
                r_max   <= '0;
                r_count <= '0;
                r_err   <= w_bad_region;
            end else begin
                if (w_issue) begin
                    if (r_x == r_x1) begin
                        r_x <= r_x0;
                        r_y <= r_y + Y_IDX'(1);
                    end else begin
                        r_x <= r_x + X_IDX'(1);
                    end
                end
                // A missing return is recorded as an error but never folded into the statistics.
                if (w_tag_out) begin
                    if (mtx_valid_i) begin
                        r_sum   <= r_sum + SUM_W'(mtx_value_i);
                        r_count <= r_count + CNT_W'(1);
                        if (mtx_value_i > r_max) r_max <= mtx_value_i;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: table vectors, random regions vs. a loop-based reference, reset corner case.
module tb_matrix_scan_ctrl;

    localparam int NX  = 4;
    localparam int NY  = 4;
    localparam int LAT = 1;

    typedef struct {
        int x0, x1, y0, y1, hold;
        bit den;
        int dx, dy;
        int sum, mx, cnt;
        bit err;
        int lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  x0, x1, y0, y1;
    logic [1:0]  mx_idx, my_idx;
    logic [7:0]  mval;
    logic        mvld;
    logic        res_valid;
    logic        res_ready;
    logic [12:0] res_sum;
    logic [7:0]  res_max;
    logic [4:0]  res_cnt;
    logic        res_err;

    int n_chk  = 0;
    int n_fail = 0;

    bit         drop_en = 1'b0;
    int         drop_x  = 0;
    int         drop_y  = 0;
    logic [1:0] prev_x  = 2'd0;
    logic [1:0] prev_y  = 2'd0;

    always #5 clk = ~clk;

    matrix_scan_ctrl #(.MAX_VALUE(255), .NUM_X(NX), .NUM_Y(NY), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_x0_i(x0), .cmd_x1_i(x1), .cmd_y0_i(y0), .cmd_y1_i(y1),
        .mtx_x_idx_o(mx_idx), .mtx_y_idx_o(my_idx),
        .mtx_value_i(mval), .mtx_valid_i(mvld),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_sum_o(res_sum), .res_max_o(res_max), .res_count_o(res_cnt), .res_err_o(res_err)
    );

    // Matrix with one-cycle read latency: cell value y*4+x, optionally one cell's return dropped.
    always @(negedge clk) begin
        mval   = 8'(int'(prev_y) * NX + int'(prev_x));
        mvld   = !(drop_en && int'(prev_x) == drop_x && int'(prev_y) == drop_y);
        prev_x = mx_idx;
        prev_y = my_idx;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.sum = 0; r.mx = 0; r.cnt = 0; r.err = 1'b0;
        if (v.x0 > v.x1 || v.y0 > v.y1 || v.x1 >= NX || v.y1 >= NY) begin
            r.err = 1'b1;
            r.lat = 1;
            return r;
        end
        for (int y = v.y0; y <= v.y1; y++) begin
            for (int x = v.x0; x <= v.x1; x++) begin
                if (v.den && x == v.dx && y == v.dy) begin
                    r.err = 1'b1;
                end else begin
                    r.sum += y * NX + x;
                    r.cnt += 1;
                    if (y * NX + x > r.mx) r.mx = y * NX + x;
                end
            end
        end
        r.lat = (v.x1 - v.x0 + 1) * (v.y1 - v.y0 + 1) + LAT + 1;
        return r;
    endfunction

    // Entered and left at a negedge; the next command may start right away.
    task automatic run_vec(input vec_t v, input string tag);
        int  lat;
        int  bad;
        int  w;
        int  n;
        bit  valid;
        valid   = (v.x0 <= v.x1) && (v.y0 <= v.y1);
        w       = v.x1 - v.x0 + 1;
        n       = valid ? w * (v.y1 - v.y0 + 1) : 0;
        drop_en = v.den;
        drop_x  = v.dx;
        drop_y  = v.dy;
        chk({tag, ":cmd_ready_idle"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        x0 = 2'(v.x0); x1 = 2'(v.x1); y0 = 2'(v.y0); y1 = 2'(v.y1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k <= n && (mx_idx != 2'((k - 1) % w + v.x0) || my_idx != 2'((k - 1) / w + v.y0)))
                bad++;
            if (res_valid) begin
                if (mx_idx != 2'd0 || my_idx != 2'd0) bad++;
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ":latency"}, lat, v.lat);
        chk({tag, ":issue_order"}, bad, 0);
        if (lat == 0) return;
        for (int h = 0; h <= v.hold; h++) begin
            chk({tag, ":sum"}, res_sum, v.sum);
            chk({tag, ":max"}, res_max, v.mx);
            chk({tag, ":count"}, res_cnt, v.cnt);
            chk({tag, ":err"}, res_err, v.err);
            chk({tag, ":valid_ready_hold"}, {res_valid, cmd_ready}, 2'b10);
            if (h == v.hold) res_ready = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b0;
        chk({tag, ":after_handshake"}, {res_valid, cmd_ready}, 2'b01);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 3, 0, 3, 0, 0, 0, 0, 120, 15, 16, 0, 18};
        tbl[1] = '{1, 2, 2, 3, 0, 0, 0, 0,  46, 14,  4, 0,  6};
        tbl[2] = '{2, 1, 0, 3, 0, 0, 0, 0,   0,  0,  0, 1,  1};
        tbl[3] = '{0, 3, 0, 3, 0, 1, 2, 1, 114, 15, 15, 1, 18};
        tbl[4] = '{3, 3, 0, 1, 5, 0, 0, 0,  10,  7,  2, 0,  4};
        tbl[5] = '{0, 0, 3, 2, 0, 0, 0, 0,   0,  0,  0, 1,  1};
        tbl[6] = '{0, 1, 0, 0, 2, 1, 1, 0,   0,  0,  1, 1,  4};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0,   0,  0,  1, 0,  3};

        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        x0 = 2'd0; x1 = 2'd0; y0 = 2'd0; y1 = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready_valid", {cmd_ready, res_valid}, 2'b10);
        chk("reset_outputs", {res_sum, res_max, res_cnt, res_err, mx_idx, my_idx}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Reset in the middle of a full-region issue phase.
        drop_en = 1'b0;
        cmd_valid = 1'b1; x0 = 2'd0; x1 = 2'd3; y0 = 2'd0; y1 = 2'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midscan_idx", {mx_idx, my_idx}, {2'd1, 2'd1});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_ready_valid", {cmd_ready, res_valid}, 2'b10);
        chk("midreset_outputs", {res_sum, res_max, res_cnt, res_err, mx_idx, my_idx}, 0);
        repeat (3) @(negedge clk);
        chk("midreset_no_inflight", {res_sum, res_cnt, res_valid}, 0);
        rv = '{3, 3, 3, 3, 0, 0, 0, 0, 15, 15, 1, 0, 3};
        run_vec(rv, "post_reset_single");

        for (int i = 0; i < 30; i++) begin
            rv.x0   = $urandom_range(0, 3);
            rv.x1   = $urandom_range(0, 3);
            rv.y0   = $urandom_range(0, 3);
            rv.y1   = $urandom_range(0, 3);
            rv.hold = $urandom_range(0, 3);
            rv.den  = 1'($urandom_range(0, 1));
            rv.dx   = $urandom_range(0, 3);
            rv.dy   = $urandom_range(0, 3);
            rv = model(rv);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 SHALL have parameter MAX_VALUE, default 255, the largest value a matrix cell holds.
REQ-002 SHALL have parameter NUM_X, default 4, the number of matrix columns.
REQ-003 SHALL have parameter NUM_Y, default 4, the number of matrix rows.
REQ-004 SHALL have parameter LATENCY, default 1, the fixed matrix read latency in cycles, always ≥1.
REQ-005 SHALL derive NUM_WIDTH=$clog2(MAX_VALUE+1), X_IDX=$clog2(NUM_X), Y_IDX=$clog2(NUM_Y), CNT_W=$clog2(NUM_X*NUM_Y+1) and SUM_W=NUM_WIDTH+CNT_W.
REQ-006 Ports SHALL be:
  clk_i  in  1  single clock, all logic on its rising edge
  rst_i  in  1  synchronous reset, active-high
  cmd_valid_i  in  1  region scan request
  cmd_ready_o  out  1  controller can accept a command
  cmd_x0_i / cmd_x1_i  in  X_IDX  first/last column, inclusive
  cmd_y0_i / cmd_y1_i  in  Y_IDX  first/last row, inclusive
  mtx_x_idx_o  out  X_IDX  column index to the matrix
  mtx_y_idx_o  out  Y_IDX  row index to the matrix
  mtx_value_i  in  NUM_WIDTH  matrix read data
  mtx_valid_i  in  1  matrix read data valid
  res_valid_o  out  1  result available
  res_ready_i  in  1  consumer takes the result
  res_sum_o  out  SUM_W  sum of the sampled cells
  res_max_o  out  NUM_WIDTH  maximum sampled cell value
  res_count_o  out  CNT_W  number of cells sampled
  res_err_o  out  1  bad region or sample lost

Function
REQ-007 SHALL implement a state machine with states IDLE, ISSUE, DRAIN and DONE.
REQ-008 SHALL drive cmd_ready_o high only in IDLE; a command is accepted in cycle T when cmd_valid_i and cmd_ready_o are both high.
REQ-009 SHALL register the region on acceptance and clear sum, max, count and err in that same cycle.
REQ-010 SHALL treat a region as invalid if x0>x1, y0>y1, x1≥NUM_X or y1≥NUM_Y.
  Invalid region: go directly to DONE with err=1 and count=0.
  Valid region: go to ISSUE.
REQ-011 In ISSUE, SHALL drive one index pair per cycle, starting at cycle T+1.
  Order is row-major: x steps from x0 to x1, then wraps to x0 with y+1.
  Issue ends after the pair (x1,y1), so N=(x1-x0+1)*(y1-y0+1) pairs are issued.
REQ-012 SHALL track each issued pair with a LATENCY-deep tag shift register.
  A tag emerging from the register means the return is expected in that cycle.
REQ-013 When a tag emerges and mtx_valid_i=1, SHALL sample mtx_value_i: sum+=value, max=max(max,value), count+=1.
REQ-014 When a tag emerges and mtx_valid_i=0, SHALL leave sum, max and count unchanged and set err=1 (sticky until the next command).
REQ-015 SHALL ignore mtx_valid_i whenever no tag emerges.
REQ-016 After the last issue, SHALL enter DRAIN and stay there until the tag register is empty, then enter DONE.
  res_valid_o first rises at cycle T+N+LATENCY+1.
REQ-017 In DONE, SHALL hold res_valid_o=1 and all res_* outputs stable until res_ready_i=1, then return to IDLE on the next edge.
REQ-018 A new command SHALL be accepted no earlier than the cycle after the result handshake.
REQ-019 In IDLE and DONE, SHALL drive mtx_x_idx_o and mtx_y_idx_o to 0.
REQ-020 SUM_W SHALL be wide enough that the sum never overflows; max SHALL compare unsigned.

Reset
REQ-021 rst_i=1 at any rising edge, including mid-ISSUE or mid-DRAIN, SHALL on that edge:
  enter IDLE and clear the tag register;
  set cmd_ready_o=1 and res_valid_o=0;
  set res_sum_o, res_max_o, res_count_o, res_err_o, mtx_x_idx_o and mtx_y_idx_o to 0.
REQ-022 Returns in flight when reset is applied SHALL be discarded and never counted.

Verification
Bench setup for all scenarios: NUM_X=NUM_Y=4, LATENCY=1, matrix model value = y*4+x.
REQ-023 Full scan (0,0)-(3,3), result accepted at once -> sum=120, max=15, count=16, err=0; res_valid_o at T+18.
REQ-024 Sub-region x0=1,x1=2,y0=2,y1=3 -> pairs issued in order (1,2),(2,2),(1,3),(2,3); sum=46, max=14, count=4.
REQ-025 Invalid command x0=2,x1=1 -> res_valid_o at T+1, err=1, count=0, sum=0; no pairs issued.
REQ-026 Full scan with mtx_valid_i forced low for the return of cell (2,1) -> count=15, sum=114, max=15, err=1.
REQ-027 Backpressure: res_ready_i held low 5 cycles after res_valid_o rises -> outputs stable, cmd_ready_o=0 throughout; a new command is accepted the cycle after the handshake.
REQ-028 rst_i pulsed for 1 cycle during ISSUE of a full scan -> IDLE and all outputs 0 next cycle; a following single-cell scan (3,3)-(3,3) gives sum=15, count=1, err=0.
